// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4-bit barrel shifter, with a
// one-entry tagged result register. Define GRANT_CNT_EN for per-requester saturating grant counters.
module shift_req_arbiter #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_valid,
    output logic       o_a_ready,
    input  logic [3:0] i_a_data,
    input  logic [1:0] i_a_amt,
    input  logic [1:0] i_a_op,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    input  logic [3:0] i_b_data,
    input  logic [1:0] i_b_amt,
    input  logic [1:0] i_b_op,
    output logic       o_resp_valid,
    input  logic       i_resp_ready,
    output logic [3:0] o_resp_data,
`ifdef GRANT_CNT_EN
    output logic [7:0] o_a_grants,
    output logic [7:0] o_b_grants,
`endif
    output logic       o_resp_id
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_grant;
    logic [3:0] r_data;
    logic       r_id;

    logic       w_can_accept;
    logic       w_grant_b;
    logic       w_a_fire;
    logic       w_b_fire;
    logic       w_fire;
    logic [3:0] w_sel_data;
    logic [1:0] w_sel_amt;
    logic [1:0] w_sel_op;
    logic [3:0] w_shift;

    // Rotates use a doubled operand so the wrapped bits fall out of a plain shift.
    function automatic logic [3:0] f_shift(input logic [3:0] d, input logic [1:0] amt,
                                           input logic [1:0] op);
        logic [7:0] dd;
        dd = {d, d};
        case (op)
            2'b00:   f_shift = d << amt;
            2'b01:   f_shift = d >> amt;
            2'b10:   begin dd = dd << amt; f_shift = dd[7:4]; end
            default: begin dd = dd >> amt; f_shift = dd[3:0]; end
        endcase
    endfunction

    assign w_can_accept = (r_state == EMPTY) || i_resp_ready;
    // On a tie the requester that did not win last time gets the grant.
    assign w_grant_b    = i_b_valid && (!i_a_valid || !r_last_grant);
    assign o_a_ready    = !i_rst && w_can_accept && i_a_valid && !w_grant_b;
    assign o_b_ready    = !i_rst && w_can_accept && w_grant_b;
    assign w_a_fire     = i_a_valid && o_a_ready;
    assign w_b_fire     = i_b_valid && o_b_ready;
    assign w_fire       = w_a_fire || w_b_fire;

    assign w_sel_data   = w_grant_b ? i_b_data : i_a_data;
    assign w_sel_amt    = w_grant_b ? i_b_amt  : i_a_amt;
    assign w_sel_op     = w_grant_b ? i_b_op   : i_a_op;
    assign w_shift      = f_shift(w_sel_data, w_sel_amt, w_sel_op);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_fire) w_state_nxt = FULL;
            FULL:    if (!w_fire && i_resp_ready) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= EMPTY;
            r_last_grant <= RR_INIT;
            r_data       <= 4'd0;
            r_id         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_data       <= w_shift;
                r_id         <= w_grant_b;
                r_last_grant <= w_grant_b;
            end
        end
    end

    assign o_resp_valid = (r_state == FULL);
    assign o_resp_data  = r_data;
    assign o_resp_id    = r_id;

`ifdef GRANT_CNT_EN
    logic [7:0] r_a_grants;
    logic [7:0] r_b_grants;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_grants <= 8'd0;
            r_b_grants <= 8'd0;
        end else begin
            if (w_a_fire && (r_a_grants != 8'hFF)) r_a_grants <= r_a_grants + 8'd1;
            if (w_b_fire && (r_b_grants != 8'hFF)) r_b_grants <= r_b_grants + 8'd1;
        end
    end

    assign o_a_grants = r_a_grants;
    assign o_b_grants = r_b_grants;
`endif

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Scoreboard bench for shift_req_arbiter: a reference arbiter/shifter model predicts
// ready, valid and each result; results are queued at transfer and compared at drain.
module tb_shift_req_arbiter;
    localparam logic RR_INIT = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [3:0] a_data, b_data;
    logic [1:0] a_amt, a_op, b_amt, b_op;
    logic       resp_valid, resp_ready, resp_id;
    logic [3:0] resp_data;
`ifdef GRANT_CNT_EN
    logic [7:0] a_grants, b_grants;
`endif

    always #5 clk = ~clk;

    shift_req_arbiter #(.RR_INIT(RR_INIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_data(a_data), .i_a_amt(a_amt), .i_a_op(a_op),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_data(b_data), .i_b_amt(b_amt), .i_b_op(b_op),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
`ifdef GRANT_CNT_EN
        .o_a_grants(a_grants), .o_b_grants(b_grants),
`endif
        .o_resp_id(resp_id)
    );

    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [3:0] ref_shift(input logic [3:0] d, input int amt, input logic [1:0] op);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 4; i++) begin
            case (op)
                2'd0: if (i + amt < 4) r[i+amt] = d[i];
                2'd1: if (i - amt >= 0) r[i-amt] = d[i];
                2'd2: r[(i+amt)%4] = d[i];
                default: r[(i-amt+4)%4] = d[i];
            endcase
        end
        return r;
    endfunction

    logic m_full, m_last, e_acc, e_gb, e_ar, e_br;
    int   m_ag, m_bg;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            m_full = 1'b0;
            m_last = RR_INIT;
            m_ag = 0;
            m_bg = 0;
            q.delete();
        end else begin
            e_acc = !m_full || resp_ready;
            e_gb  = (a_valid && b_valid) ? !m_last : b_valid;
            e_ar  = e_acc && a_valid && !e_gb;
            e_br  = e_acc && b_valid && e_gb;
            chk("a_ready", a_ready, e_ar);
            chk("b_ready", b_ready, e_br);
            chk("resp_valid", resp_valid, m_full);
`ifdef GRANT_CNT_EN
            chk("a_grants", a_grants, m_ag);
            chk("b_grants", b_grants, m_bg);
`endif
            if (m_full && resp_ready) begin
                if (q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_id", resp_id, e.id);
                end
            end
            if (e_ar || e_br) begin
                e.id   = e_gb;
                e.data = e_gb ? ref_shift(b_data, b_amt, b_op) : ref_shift(a_data, a_amt, a_op);
                q.push_back(e);
                m_last = e_gb;
                m_full = 1'b1;
                if (e_gb) m_bg = (m_bg < 255) ? m_bg + 1 : 255;
                else      m_ag = (m_ag < 255) ? m_ag + 1 : 255;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [3:0] d, input logic [1:0] amt, input logic [1:0] op);
        a_valid = v; a_data = d; a_amt = amt; a_op = op;
    endtask

    task automatic drive_b(input logic v, input logic [3:0] d, input logic [1:0] amt, input logic [1:0] op);
        b_valid = v; b_data = d; b_amt = amt; b_op = op;
    endtask

    logic a_fire, b_fire;

    initial begin
        rst = 1'b1;
        resp_ready = 1'b1;
        drive_a(0, 4'd0, 2'd0, 2'd0);
        drive_b(0, 4'd0, 2'd0, 2'd0);
        cyc(); cyc();
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_id", resp_id, 0);
`ifdef GRANT_CNT_EN
        chk("reset_a_grants", a_grants, 0);
        chk("reset_b_grants", b_grants, 0);
`endif
        rst = 1'b0;
        cyc();

        // A only, rotate left by 1, held in the register for the reset test
        drive_a(1, 4'b1001, 2'd1, 2'b10);
        resp_ready = 1'b0;
        #1 chk("first_a_ready", a_ready, 1);
        cyc();
        drive_a(0, 4'd0, 2'd0, 2'd0);
        chk("first_valid", resp_valid, 1);
        chk("first_data", resp_data, 4'b0011);
        chk("first_id", resp_id, 0);
        #1 rst = 1'b1;
        #1 chk("async_rst_valid", resp_valid, 0);
        chk("async_rst_data", resp_data, 0);
        cyc(); cyc();
        rst = 1'b0;
        resp_ready = 1'b1;

        // Both valid: last_grant back at RR_INIT so A first, then strict alternation
        drive_a(1, 4'b1011, 2'd2, 2'b00);
        drive_b(1, 4'b0001, 2'd1, 2'b11);
        cyc();
        chk("alt_first_data", resp_data, 4'b1100);
        chk("alt_first_id", resp_id, 0);
        cyc();
        chk("alt_second_data", resp_data, 4'b1000);
        chk("alt_second_id", resp_id, 1);
        repeat (6) cyc();
        drive_a(0, 4'd0, 2'd0, 2'd0);
        drive_b(0, 4'd0, 2'd0, 2'd0);
        cyc(); cyc();

        // Backpressure: result held and no requester accepted
        drive_a(1, 4'b1011, 2'd2, 2'b00);
        resp_ready = 1'b0;
        cyc();
        drive_b(1, 4'b0101, 2'd1, 2'b01);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_data", resp_data, 4'b1100);
            chk("bp_valid", resp_valid, 1);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
        end
        drive_a(0, 4'd0, 2'd0, 2'd0);
        drive_b(0, 4'd0, 2'd0, 2'd0);
        resp_ready = 1'b1;
        cyc();
        chk("bp_drained", resp_valid, 0);
        chk("bp_data_kept", resp_data, 4'b1100);

        // B only logical right by 3; A with amount 0 under every op
        drive_b(1, 4'b1000, 2'd3, 2'b01);
        cyc();
        chk("b_only_data", resp_data, 4'b0001);
        chk("b_only_id", resp_id, 1);
        drive_b(0, 4'd0, 2'd0, 2'd0);
        for (int op = 0; op < 4; op++) begin
            drive_a(1, 4'b0110, 2'd0, 2'(op));
            cyc();
            chk("amt0_data", resp_data, 4'b0110);
        end
        drive_a(0, 4'd0, 2'd0, 2'd0);
        cyc();

        // Random traffic; operands change only when idle or just accepted
        a_fire = 1'b0;
        b_fire = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!a_valid || a_fire)
                drive_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (!b_valid || b_fire)
                drive_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            resp_ready = ($urandom_range(0, 3) != 0);
            #2;
            a_fire = a_valid && a_ready;
            b_fire = b_valid && b_ready;
            cyc();
        end
        drive_a(0, 4'd0, 2'd0, 2'd0);
        drive_b(0, 4'd0, 2'd0, 2'd0);
        resp_ready = 1'b1;
        cyc(); cyc();

        // 300 back-to-back A transfers from a fresh reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive_a(1, 4'b1001, 2'd1, 2'b10);
        repeat (300) cyc();
`ifdef GRANT_CNT_EN
        chk("sat_a_grants", a_grants, 255);
        chk("sat_b_grants", b_grants, 0);
`endif
        chk("b2b_valid", resp_valid, 1);
        drive_a(0, 4'd0, 2'd0, 2'd0);
        cyc(); cyc();
        chk("sb_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
